// File: rtl/dmem_dma.sv
// rtl/dmem_dma.sv - block word-copy engine mastering the data-memory port, with running checksum
module dmem_dma #(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [31:0]      Address,
    output logic [31:0]      Write_data,
    input  logic [31:0]      Read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      sum_q, sum_d;
    logic             desc_q, desc_d;

    // Word-aligned request addresses; the low two bits are simply masked off.
    logic [31:0] src_al;
    logic [31:0] dst_al;
    // Byte offset of the last word of the block, used as the start point when copying downward.
    logic [31:0] last_off;
    // One-past-the-end word address of the source block, kept one bit wider so it never wraps.
    logic [30:0] src_end_w;
    logic        fwd_overlap;
    logic [31:0] step;

    // Request decode: alignment, overlap detection and the descending start offset.
    always_comb begin
        src_al      = src_addr & 32'hFFFF_FFFC;
        dst_al      = dst_addr & 32'hFFFF_FFFC;
        last_off    = (32'(length) - 32'd1) << 2;
        src_end_w   = {1'b0, src_al[31:2]} + 31'(length);
        fwd_overlap = (dst_al[31:2] > src_al[31:2]) && ({1'b0, dst_al[31:2]} < src_end_w);
        step        = desc_q ? 32'hFFFF_FFFC : 32'd4;
    end

    // Next-state logic for the copy sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        sum_d   = sum_q;
        desc_d  = desc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A destination inside the source block ahead of it would be clobbered
                    // before being read when going upward, so that case copies downward.
                    desc_d = fwd_overlap;
                    src_d  = fwd_overlap ? (src_al + last_off) : src_al;
                    dst_d  = fwd_overlap ? (dst_al + last_off) : dst_al;
                    cnt_d  = length;
                    sum_d  = 32'd0;
                    state_d = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                buf_d   = Read_data;
                sum_d   = sum_q + Read_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = cnt_q - LEN_W'(1);
                src_d   = src_q + step;
                dst_d   = dst_q + step;
                state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            cnt_q   <= '0;
            buf_q   <= 32'd0;
            sum_q   <= 32'd0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            sum_q   <= sum_d;
            desc_q  <= desc_d;
        end
    end

    // Memory strobes and status come only from registered state, never from start.
    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'd0;
        Write_data = 32'd0;
        case (state_q)
            S_READ: begin
                MemRead = 1'b1;
                Address = src_q;
            end
            S_WRITE: begin
                MemWrite   = 1'b1;
                Address    = dst_q;
                Write_data = buf_q;
            end
            default: begin
                MemRead = 1'b0;
            end
        endcase
        busy     = (state_q == S_READ) || (state_q == S_WRITE);
        done     = (state_q == S_DONE);
        checksum = sum_q;
    end

endmodule

// File: doc/dmem_dma.md
# dmem_dma

Word-copy engine that masters the data-memory port: it drives `MemRead`/`MemWrite`/`Address`/`Write_data` and consumes `Read_data`. It is the initiator for the data memory (combinational read, write on clock edge). It sits beside the CPU's load/store path behind the bus mux and moves a block of words from a source to a destination address. It also returns a running checksum of the copied words.

## Interface
- `LEN_W`, default 9: width of the word-count input. Maximum length is 2^LEN_W − 1 words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `src_addr`  in  32  source byte address; bits [1:0] ignored (treated as 0).
- `dst_addr`  in  32  destination byte address; bits [1:0] ignored.
- `length`  in  LEN_W  number of 32-bit words to copy.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `checksum`  out  32  sum mod 2^32 of all words copied; held until the next accepted start.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `Address`  out  32  memory byte address.
- `Write_data`  out  32  memory write data.
- `Read_data`  in  32  memory read data, valid in the same cycle as `Address` while `MemRead`=1.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**, `start`=1:
  - Latch `src`/`dst` with bits [1:0] cleared, and latch `length`.
  - Clear `checksum`.
  - If `length`=0, go to DONE. Otherwise choose the direction and go to READ.
- **Direction**, computed on word addresses (`addr[31:2]`):
  - Descending if `dst` > `src` and `dst` < `src` + `length` (forward overlap).
  - Ascending otherwise, including `dst` = `src`.
  - Descending: the first word is at `src` + 4·(`length`−1) and `dst` + 4·(`length`−1), and pointers step −4.
  - Ascending: the first word is at `src` and `dst`, and pointers step +4.
  - Pointer arithmetic is 32-bit modulo 2^32; wrap-around is permitted.
- **READ**: `MemRead`=1, `Address`=`src` pointer. At the edge: latch `Read_data` into the data buffer, add it to `checksum`, go to WRITE.
- **WRITE**: `MemWrite`=1, `Address`=`dst` pointer, `Write_data`=buffer. At the edge: decrement the remaining count and step both pointers. Go to DONE if the remaining count reaches 0, else to READ.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Outside READ and WRITE: `MemRead`=`MemWrite`=0, `Address`=0, `Write_data`=0. `MemRead` and `MemWrite` are never both 1.
- Strobes and the address are decoded from registered state and pointers only. There is no combinational path from `start` to memory outputs.
- Reset values: state IDLE; `busy`, `done`, `MemRead`, `MemWrite`, `Address`, `Write_data` and `checksum` all 0; internal pointers, count and buffer all 0.
- Reset mid-transfer aborts immediately. Words already written remain. The word in flight is not written unless its WRITE edge preceded reset.

## Timing
- Cycle 0 is the IDLE cycle where `start`=1 is sampled.
- For `length`=N>0:
  - Word k (0-based) occupies cycle 2k+1 (READ) and cycle 2k+2 (WRITE).
  - `done`=1 in cycle 2N+1.
  - IDLE in cycle 2N+2; a new start can be sampled there.
- For `length`=0: `done`=1 in cycle 1, with no memory strobes.
- `busy`=1 for exactly 2N cycles.
- `checksum` is final from cycle 2N (after the last READ edge) and stable in the `done` cycle.
- Throughput is one word per 2 cycles. No wait states: the memory is assumed zero-latency read.

## Test plan
Memory is preloaded with word16=0x14, word17=0x41a8, word18=0x3af2, word19=0xacda.
- **Basic copy.** `src`=0x44, `dst`=0x200, `length`=3.
  - Word128..130 = 0x41a8, 0x3af2, 0xacda.
  - `checksum`=0x12974.
  - `done` in cycle 7 only; `busy` for 6 cycles.
- **Forward overlap.** `src`=0x40, `dst`=0x44, `length`=3.
  - Address sequence: R 0x48, W 0x4C, R 0x44, W 0x48, R 0x40, W 0x44.
  - Word16..19 = 0x14, 0x14, 0x41a8, 0x3af2.
  - `checksum`=0x7cae.
- **Backward overlap.** `src`=0x44, `dst`=0x40, `length`=2.
  - Ascending order.
  - Word16=0x41a8, word17=0x3af2.
- **Unaligned, zero, busy start.**
  - `src`=0x47, `dst`=0x203, `length`=1: behaves as 0x44 → 0x200.
  - `length`=0: `done` in cycle 1, `MemRead`/`MemWrite` never 1.
  - `start` pulsed in cycle 2 of a 3-word copy: ignored.
- **Reset mid-transfer.** `length`=4, `rst` asserted during cycle 3 (second READ).
  - All outputs 0 immediately.
  - Only the first destination word is written.
  - After release, a new start runs normally.
